// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the RV32I core's integer register unit.
//   XLEN        default data width
//   REG_ADDR_W  width of the rs1/rs2/rd register index fields
//   SP_INIT     default reset value of x2 (stack pointer)
//   ru_state_t  register-unit lifecycle: SCRUB -> INIT_SP -> RUN
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int          XLEN       = 32;
    localparam int          REG_ADDR_W = 5;
    localparam logic [31:0] SP_INIT    = 32'h0000_0FFC;

    typedef enum logic [1:0] {
        SCRUB   = 2'd0,
        INIT_SP = 2'd1,
        RUN     = 2'd2
    } ru_state_t;

endpackage : riscv_pkg

// File: rtl/register_unit_scrub_fsm.sv
// ---------------------------------------------------------------------------
// register_unit_scrub_fsm
// Post-reset initialisation sequencer for the register array. It zeroes
// x1..x(NREGS-1) one per cycle, then loads SP_INIT into x2, then hands
// the write port to the core and raises ru_ready.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset (restarts the scrub)
//   state     out  current lifecycle state (also serves as a debug tap)
//   ru_ready  out  registered; high only in RUN
//   fsm_wr    out  write-port mux select: 1 = FSM owns the array write port
//   fsm_addr  out  FSM write address (valid while fsm_wr = 1)
//   fsm_data  out  FSM write data    (valid while fsm_wr = 1)
// ---------------------------------------------------------------------------
module register_unit_scrub_fsm #(
    parameter int               NREGS   = 32,
    parameter int               XLEN    = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(riscv_pkg::SP_INIT),
    parameter int               AW      = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    output riscv_pkg::ru_state_t  state,
    output logic                  ru_ready,
    output logic                  fsm_wr,
    output logic [AW-1:0]         fsm_addr,
    output logic [XLEN-1:0]       fsm_data
);
    import riscv_pkg::*;

    logic [AW-1:0] scrub_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SCRUB;
            scrub_idx <= AW'(1);   // x0 is hard-wired, never stored
            ru_ready  <= 1'b0;
        end else begin
            case (state)
                SCRUB: begin
                    if (scrub_idx == AW'(NREGS - 1)) begin
                        state <= INIT_SP;
                    end else begin
                        scrub_idx <= scrub_idx + 1'b1;
                    end
                end
                INIT_SP: begin
                    state    <= RUN;
                    ru_ready <= 1'b1;
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state     <= SCRUB;
                    scrub_idx <= AW'(1);
                    ru_ready  <= 1'b0;
                end
            endcase
        end
    end

    // The FSM drives the array write port in every state except RUN.
    always_comb begin
        fsm_wr   = (state != RUN);
        fsm_addr = (state == SCRUB) ? scrub_idx : AW'(2);
        fsm_data = (state == SCRUB) ? '0 : SP_INIT;
    end

endmodule : register_unit_scrub_fsm

// File: rtl/register_unit.sv
// ---------------------------------------------------------------------------
// register_unit
// Integer register file x0..x(NREGS-1) for the single-cycle RV32I core.
// Storage has no per-entry reset (maps to distributed RAM); after reset a
// scrub sequencer clears it and raises ru_ready.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous active-high reset
//   ru_wr        in   write enable from the control unit (RUN only)
//   rd           in   destination index; rd = 0 is ignored
//   ru_wrdata    in   writeback data
//   rs1, rs2     in   source indices
//   ru_rs1/2     out  combinational read data (x0 reads 0)
//   ru_ready     out  high once initialisation is complete
//   ru_wr_count  out  number of committed architectural writes (wraps)
//
// Build option REGISTER_UNIT_BYPASS_EN: when defined, a read of the
// register being written in the same RUN cycle returns ru_wrdata
// (write-through). Otherwise reads return the pre-edge contents.
// ---------------------------------------------------------------------------
module register_unit #(
    parameter int               NREGS   = 32,
    parameter int               XLEN    = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]  SP_INIT = XLEN'(riscv_pkg::SP_INIT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 ru_wr,
    input  logic        [riscv_pkg::REG_ADDR_W-1:0] rd,
    input  logic signed [XLEN-1:0]               ru_wrdata,
    input  logic        [riscv_pkg::REG_ADDR_W-1:0] rs1,
    input  logic        [riscv_pkg::REG_ADDR_W-1:0] rs2,
    output logic signed [XLEN-1:0]               ru_rs1,
    output logic signed [XLEN-1:0]               ru_rs2,
    output logic                                 ru_ready,
    output logic        [31:0]                   ru_wr_count
);
    import riscv_pkg::*;

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    ru_state_t       state;
    logic            fsm_wr;
    logic [AW-1:0]   fsm_addr;
    logic [XLEN-1:0] fsm_data;

    register_unit_scrub_fsm #(
        .NREGS   (NREGS),
        .XLEN    (XLEN),
        .SP_INIT (SP_INIT),
        .AW      (AW)
    ) u_scrub_fsm (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .ru_ready (ru_ready),
        .fsm_wr   (fsm_wr),
        .fsm_addr (fsm_addr),
        .fsm_data (fsm_data)
    );

    // An architectural write commits only in RUN, to an implemented,
    // non-zero register, and not on a reset edge.
    logic core_wr;
    always_comb begin
        core_wr = ru_wr && (state == RUN) && !rst
                  && (rd != '0) && (32'(rd) < NREGS);
    end

    always_ff @(posedge clk) begin
        if (fsm_wr) begin
            regs[fsm_addr] <= fsm_data;
        end else if (core_wr) begin
            regs[rd[AW-1:0]] <= ru_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ru_wr_count <= '0;
        end else if (core_wr) begin
            ru_wr_count <= ru_wr_count + 32'd1;
        end
    end

    // x0 and indices beyond NREGS read as zero.
    always_comb begin
        ru_rs1 = '0;
        ru_rs2 = '0;
        if (rs1 != '0 && 32'(rs1) < NREGS) begin
            ru_rs1 = regs[rs1[AW-1:0]];
        end
        if (rs2 != '0 && 32'(rs2) < NREGS) begin
            ru_rs2 = regs[rs2[AW-1:0]];
        end
`ifdef REGISTER_UNIT_BYPASS_EN
        if (core_wr && rd == rs1) begin
            ru_rs1 = ru_wrdata;
        end
        if (core_wr && rd == rs2) begin
            ru_rs2 = ru_wrdata;
        end
`endif
    end

endmodule : register_unit

// File: tb/tb_register_unit.sv
// ---------------------------------------------------------------------------
// tb_register_unit
// Self-checking bench for register_unit: directed scenarios plus a block
// of randomized read/write cycles compared against an array model.
// ---------------------------------------------------------------------------
module tb_register_unit;

    localparam logic [31:0] SP = 32'h0000_0FFC;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ru_wr = 1'b0;
    logic        [4:0]  rd = '0;
    logic signed [31:0] ru_wrdata = '0;
    logic        [4:0]  rs1 = '0;
    logic        [4:0]  rs2 = '0;
    logic signed [31:0] ru_rs1;
    logic signed [31:0] ru_rs2;
    logic               ru_ready;
    logic        [31:0] ru_wr_count;

    register_unit dut (
        .clk         (clk),
        .rst         (rst),
        .ru_wr       (ru_wr),
        .rd          (rd),
        .ru_wrdata   (ru_wrdata),
        .rs1         (rs1),
        .rs2         (rs2),
        .ru_rs1      (ru_rs1),
        .ru_rs2      (ru_rs2),
        .ru_ready    (ru_ready),
        .ru_wr_count (ru_wr_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [32];
    logic [31:0] exp_count;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Value a read port should show this cycle, given the pending write.
    function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic wr,
                                             input logic [4:0] wa, input logic [31:0] data);
        if (idx == 5'd0) return 32'd0;
`ifdef REGISTER_UNIT_BYPASS_EN
        if (wr && wa != 5'd0 && wa == idx) return data;
`endif
        return model[idx];
    endfunction

    task automatic model_after_scrub();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[2]  = SP;
        exp_count = 32'd0;
    endtask

    // Pulse reset for one edge, then measure how long ru_ready stays low.
    // hold_wr keeps a write to x3 requested throughout initialisation.
    task automatic reset_and_wait(input logic hold_wr);
        int n;
        rst       = 1'b1;
        ru_wr     = hold_wr;
        rd        = 5'd3;
        ru_wrdata = $urandom;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ready_after_rst", {31'd0, ru_ready}, 32'd0);
        check("count_after_rst", ru_wr_count, 32'd0);
        n = 0;
        while (!ru_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_latency", n, 32);
        ru_wr = 1'b0;
        rd    = 5'd0;
        model_after_scrub();
    endtask

    task automatic check_all_regs();
        ru_wr = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            check($sformatf("all_rs1_x%0d", i), ru_rs1, model[i]);
            check($sformatf("all_rs2_x%0d", 31 - i), ru_rs2, model[31 - i]);
        end
    endtask

    // One core cycle: drive, check reads before the edge, then check count.
    task automatic cycle(input logic wr, input logic [4:0] wa, input logic [31:0] data,
                         input logic [4:0] a, input logic [4:0] b);
        ru_wr     = wr;
        rd        = wa;
        ru_wrdata = data;
        rs1       = a;
        rs2       = b;
        #1;
        exp_q.push_back(exp_read(a, wr, wa, data));
        exp_q.push_back(exp_read(b, wr, wa, data));
        check($sformatf("rs1_x%0d", a), ru_rs1, exp_q.pop_front());
        check($sformatf("rs2_x%0d", b), ru_rs2, exp_q.pop_front());
        @(posedge clk); #1;
        if (wr && wa != 5'd0) begin
            model[wa] = data;
            exp_count = exp_count + 32'd1;
        end
        ru_wr = 1'b0;
        check("wr_count", ru_wr_count, exp_count);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        // Initialisation while a write to x3 is held: must not count or land.
        reset_and_wait(1'b1);
        check("x3_after_scrub", ru_rs1 == ru_rs1 ? 32'd0 : 32'd1, 32'd0);
        check_all_regs();

        // Basic write then read-back.
        cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 5'd5, 5'd2);
        check("count_after_x5", ru_wr_count, 32'd1);

        // Write to x0 is dropped and not counted.
        cycle(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // Same-cycle write/read of x7, then the following cycle.
        cycle(1'b1, 5'd7, 32'hFFFF_FFF0, 5'd1, 5'd7);
        cycle(1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

        // Randomized traffic with a bias towards read-after-write hazards.
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  wa;
            logic [4:0]  a;
            logic [4:0]  b;
            wa = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            b  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            cycle(1'($urandom_range(0, 1)), wa, $urandom, a, b);
        end
        check_all_regs();

        // Reset mid-scrub: put a value in x20, reset, abort scrub at index 10.
        cycle(1'b1, 5'd20, 32'h0000_0055, 5'd0, 5'd0);
        cycle(1'b0, 5'd0, 32'd0, 5'd20, 5'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        check("ready_mid_scrub", {31'd0, ru_ready}, 32'd0);
        reset_and_wait(1'b0);
        rs1 = 5'd20;
        rs2 = 5'd20;
        #1;
        check("x20_rs1_cleared", ru_rs1, 32'd0);
        check("x20_rs2_cleared", ru_rs2, 32'd0);
        check_all_regs();
        cycle(1'b1, 5'd9, $urandom, 5'd9, 5'd2);
        cycle(1'b0, 5'd0, 32'd0, 5'd9, 5'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_register_unit
